// File: rtl/folded_fir_ctrl.sv
// Sequencer for a folded FIR: one shared MAC walks all TAPS taps per output sample.
// Define FOLDED_FIR_ZERO_FILL_EN to mask taps whose samples have not arrived yet.
module folded_fir_ctrl #(
  parameter int TAPS   = 5,
  parameter int ADDR_W = 3
) (
  input  logic              clk100,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              in_ld,
  output logic              smp_we,
  output logic [ADDR_W-1:0] smp_waddr,
  output logic [ADDR_W-1:0] smp_raddr,
  output logic              tap0_byp,
  output logic [ADDR_W-1:0] coef_sel,
  output logic              zero_tap,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]   NT   = (ADDR_W + 1)'(TAPS);

  typedef enum logic {IDLE, MAC} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic [ADDR_W-1:0] raddr_q, raddr_c;
  logic              last;

  assign last = (k == LAST);

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      k         <= '0;
      wptr      <= LAST;
      raddr_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      wptr      <= wptr_nxt;
      out_valid <= busy && last;
      if (busy) raddr_q <= raddr_c;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    wptr_nxt  = wptr;
    busy      = (state == MAC);
    in_ready  = (state == IDLE) || last;
    in_ld     = in_valid && in_ready;
    acc_en    = busy;
    acc_clr   = busy && (k == '0);
    tap0_byp  = busy && (k == '0);
    smp_we    = busy && (k == '0);
    smp_waddr = busy ? wptr : '0;
    coef_sel  = k;
    // circular read: newest sample minus tap index, wrapping mod TAPS
    if (wptr >= k) raddr_c = wptr - k;
    else raddr_c = ADDR_W'({1'b0, wptr} + NT - {1'b0, k});
    smp_raddr = busy ? raddr_c : raddr_q;
    if (in_ld) begin
      state_nxt = MAC;
      k_nxt     = '0;
      wptr_nxt  = (wptr == LAST) ? '0 : wptr + 1'b1;
    end else if (busy) begin
      if (last) state_nxt = IDLE;
      else k_nxt = k + 1'b1;
    end
  end

`ifdef FOLDED_FIR_ZERO_FILL_EN
  logic [ADDR_W:0] fill;

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) fill <= '0;
    else if (in_ld && fill != NT) fill <= fill + 1'b1;
  end

  assign zero_tap = busy && ({1'b0, k} >= fill);
`else
  assign zero_tap = 1'b0;
`endif

endmodule

// File: tb/tb_folded_fir_ctrl.sv
// Directed bench for folded_fir_ctrl (TAPS=5); follows FOLDED_FIR_ZERO_FILL_EN.
module tb_folded_fir_ctrl;

  logic       clk100 = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, in_ld, smp_we, tap0_byp, zero_tap;
  logic       acc_clr, acc_en, out_valid, busy;
  logic [2:0] smp_waddr, smp_raddr, coef_sel;

  int nvec = 0;
  int nerr = 0;

`ifdef FOLDED_FIR_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  folded_fir_ctrl #(.TAPS(5), .ADDR_W(3)) dut (
    .clk100(clk100), .rstn(rstn), .in_valid(in_valid),
    .in_ready(in_ready), .in_ld(in_ld), .smp_we(smp_we),
    .smp_waddr(smp_waddr), .smp_raddr(smp_raddr),
    .tap0_byp(tap0_byp), .coef_sel(coef_sel), .zero_tap(zero_tap),
    .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid),
    .busy(busy)
  );

  always #5 clk100 = ~clk100;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".strobes"},
        {smp_we, acc_en, acc_clr, tap0_byp, zero_tap, out_valid}, 0);
  endtask

  task automatic chk_rst(input string tag);
    chk_idle(tag);
    chk({tag, ".in_ld"}, in_ld, 0);
    chk({tag, ".addrs"}, {smp_waddr, smp_raddr, coef_sel}, 0);
  endtask

  // one pulse after fresh reset: expects write slot 0 and startup masking
  task automatic run_single(input string tag);
    int ra [5] = '{0, 4, 3, 2, 1};
    in_valid = 1'b1;
    #1;
    chk({tag, ".ld"}, in_ld, 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk({tag, ".coef"}, coef_sel, i);
      chk({tag, ".raddr"}, smp_raddr, ra[i]);
      chk({tag, ".zero"}, zero_tap, (ZF && i > 0) ? 1 : 0);
      chk({tag, ".first"}, {smp_we, tap0_byp, acc_clr},
          (i == 0) ? 7 : 0);
      chk({tag, ".waddr"}, smp_waddr, 0);
      chk({tag, ".acc_en"}, acc_en, 1);
      chk({tag, ".ovld"}, out_valid, 0);
      chk({tag, ".ready"}, in_ready, (i == 4) ? 1 : 0);
      step();
    end
    chk({tag, ".ovld_end"}, out_valid, 1);
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".hold"}, {coef_sel, smp_raddr}, {3'd4, 3'd1});
    step();
    chk({tag, ".ovld_off"}, out_valid, 0);
  endtask

  initial begin
    // reset held, then idle
    repeat (3) step();
    chk_rst("rst");
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_rst("idle");
    end

    run_single("single");

    // streaming: sample n, tap k at cycle c = 5n + k
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 35; c++) begin
      int n, k, w;
      step();
      n = c / 5;
      k = c % 5;
      w = n % 5;
      chk("str.ready", in_ready, (k == 4) ? 1 : 0);
      chk("str.ld", in_ld, (k == 4) ? 1 : 0);
      chk("str.coef", coef_sel, k);
      chk("str.waddr", smp_waddr, w);
      chk("str.raddr", smp_raddr, (w - k + 5) % 5);
      chk("str.zero", zero_tap, (ZF && k > n) ? 1 : 0);
      chk("str.ovld", out_valid, (c >= 5 && k == 0) ? 1 : 0);
    end
    in_valid = 1'b0;

    // reset mid-MAC of the second sample
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    run_single("pre");
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid.k2", coef_sel, 2);
    #2;
    rstn = 1'b0;
    #1;
    chk_rst("async");
    repeat (2) begin
      step();
      chk("mid.ovld", out_valid, 0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post.ovld", out_valid, 0);
    end
    run_single("post");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
